// File: rtl/uart_tx_arbiter_if.sv
// Request/grant and UART-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the requester/UART side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic               uart_tx_write;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_finished;
  logic               busy;
  logic [OW-1:0]      owner;

  modport slave (
    input  req, req_data, uart_tx_finished,
    output ack, done, err, uart_tx_write, uart_tx_data, busy, owner
  );

  modport master (
    output req, req_data, uart_tx_finished,
    input  ack, done, err, uart_tx_write, uart_tx_data, busy, owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters,
// with a per-byte completion timeout.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CLK = 4095
) (
  input logic            clk,
  input logic            reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int          OW = $clog2(N_REQ);
  localparam int          CW = $clog2(TIMEOUT_CLK + 1);
  localparam int unsigned NU = N_REQ;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic              write_q, write_d;
  logic [7:0]        data_q, data_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              found;
  logic [OW-1:0]     grant_idx;
  int unsigned       idx;

  // Search owner+1 .. owner+N_REQ so the previous owner is considered last.
  always_comb begin
    found     = 1'b0;
    grant_idx = owner_q;
    idx       = 0;
    for (int unsigned i = 1; i <= NU; i++) begin
      idx = (32'(owner_q) + i) % NU;
      if (!found && bus.req[OW'(idx)]) begin
        found     = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    write_d = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d            = START;
          ack_d[grant_idx]   = 1'b1;
          owner_d            = grant_idx;
          data_d             = bus.req_data[8*grant_idx +: 8];
        end
      end
      START: begin
        write_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // finished takes priority over a timeout landing on the same edge
        if (bus.uart_tx_finished) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT_CLK)) begin
            err_d[owner_q] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      owner_q <= OW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      write_q <= write_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.uart_tx_write = write_q;
  assign bus.uart_tx_data  = data_q;
  assign bus.owner         = owner_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter: TIMEOUT_CLK, 4095, max clk cycles in WAIT before abandoning a byte.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  N_REQ  level request per requester; bit i = requester i has a byte.
REQ-006 Port: req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 Port: ack  out  N_REQ  one-cycle pulse: requester's byte latched; req/data may change next cycle.
REQ-008 Port: done  out  N_REQ  one-cycle pulse: requester's byte fully transmitted.
REQ-009 Port: err  out  N_REQ  one-cycle pulse: requester's byte abandoned on timeout.
REQ-010 Port: uart_tx_write  out  1  one-cycle start pulse to UART transmitter.
REQ-011 Port: uart_tx_data  out  8  byte to UART; held stable for the whole transfer.
REQ-012 Port: uart_tx_finished  in  1  one-cycle pulse from UART at end of stop bit.
REQ-013 Port: busy  out  1  high in any state other than IDLE.
REQ-014 Port: owner  out  $clog2(N_REQ)  index of current/last granted requester.

Function
REQ-015 FSM SHALL have states IDLE, START, WAIT.
- IDLE: if req != 0 at edge, select winner, latch its byte into uart_tx_data, ack[winner]=1 next cycle, owner=winner, -> START; else stay.
- START: uart_tx_write=1 for exactly this one cycle, -> WAIT, timeout counter cleared.
- WAIT: on uart_tx_finished -> done[owner]=1 next cycle, -> IDLE; else counter +1; counter reaching TIMEOUT_CLK -> err[owner]=1 next cycle, -> IDLE.
REQ-016 Arbitration SHALL be round-robin: search order owner+1, owner+2, ... wrapping modulo N_REQ, owner itself last; first asserted req wins.
REQ-017 owner SHALL update only on a grant; pointer wraps from N_REQ-1 to 0.
REQ-018 Latency: req sampled at edge k -> ack high cycle k+1, uart_tx_write high cycle k+2.
REQ-019 uart_tx_data SHALL change only on a grant edge in IDLE; constant through START and WAIT (UART reads it bit-by-bit).
REQ-020 uart_tx_finished SHALL be ignored in IDLE and START; done/err only from WAIT.
REQ-021 Finished and timeout on same edge: finished wins (done, no err).
REQ-022 A req dropped before grant SHALL not be served; a req held after ack SHALL be served again as a new byte.
REQ-023 At most one bit of ack, done, err SHALL be high per cycle; ack never coincides with done/err of another byte.
REQ-024 Back-to-back: after done, grant may occur on the next IDLE edge (min 1 IDLE cycle between bytes).
REQ-025 Timeout counter SHALL be $clog2(TIMEOUT_CLK+1) bits, saturating never needed (exits at TIMEOUT_CLK).

Reset
REQ-026 reset SHALL asynchronously force: state IDLE, ack=0, done=0, err=0, uart_tx_write=0, uart_tx_data=8'h00, busy=0, counter=0, owner=N_REQ-1 (so requester 0 wins first).
REQ-027 Reset mid-transfer SHALL abandon the byte with no done/err pulse; first post-reset grant follows REQ-026 pointer.

Verification
REQ-028 req=4'b0001, data0=8'hA5 -> ack=0001 cycle k+1, tx_write pulse k+2, tx_data=A5 until finished; finished -> done=0001 next cycle, busy low.
REQ-029 req=4'b1111 held, bytes 11/22/33/44 -> UART sees 11,22,33,44,11 in order; acks rotate 0,1,2,3,0.
REQ-030 After owner=2, req=4'b0101 -> requester 0 granted (3 skipped, wrap to 0), not 2.
REQ-031 TIMEOUT_CLK=16, no finished -> err[owner] pulse exactly 16 cycles after WAIT entry, state IDLE, no done.
REQ-032 Finished pulse in IDLE and in START -> no done; finished coincident with timeout -> done only.
REQ-033 reset asserted in WAIT -> outputs at reset values immediately (asynchronous); subsequent req=4'b1000 | 4'b0001 grants requester 0.
